// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: one imem request per PC over req/ack, results queued
// as {instruction, PC} for the IF/ID register; flushes drop queue and in-flight data.
module if_fetch_unit #(
  parameter int DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [31:0] pc_i,
  output logic        pc_en_o,
  input  logic        flush_i,
  input  logic        stall_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_data_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o,
  output logic [1:0]  state_o
);

  // Handshake: imem_req_o stays high with a stable imem_addr_o until a cycle with
  // imem_ack_i=1 completes the transfer; ack outside a request is ignored.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DROP = 2'd2
  } state_t;

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  state_t        state;
  logic          req_q;
  logic [31:0]   addr_q;
  logic [31:0]   inst_mem [DEPTH];
  logic [31:0]   pc_mem   [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;

  logic push;
  logic pop;
  logic issue;

  // Issue looks at the pre-pop count, so a pop never frees a slot in the same cycle.
  always_comb begin
    push  = (state == S_REQ) && imem_ack_i && !flush_i;
    pop   = (count != '0) && !stall_i && !flush_i;
    issue = (state == S_IDLE) && start_i && !flush_i && (count < CNT_FULL);
  end

  assign pc_en_o = flush_i | push;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= S_IDLE;
      req_q  <= 1'b0;
      addr_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (issue) begin
            state  <= S_REQ;
            req_q  <= 1'b1;
            addr_q <= pc_i;
          end
        end
        S_REQ: begin
          if (imem_ack_i) begin
            state <= S_IDLE;
            req_q <= 1'b0;
          end else if (flush_i) begin
            state <= S_DROP;
          end
        end
        S_DROP: begin
          // The request is still open on the bus; wait for its ack and discard it.
          if (imem_ack_i) begin
            state <= S_IDLE;
            req_q <= 1'b0;
          end
        end
        default: begin
          state <= S_IDLE;
          req_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        inst_mem[i] <= '0;
        pc_mem[i]   <= '0;
      end
    end else if (flush_i) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        inst_mem[tail] <= imem_data_i;
        pc_mem[tail]   <= addr_q;
        tail           <= tail + PTR_ONE;
      end
      if (pop) begin
        head <= head + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  assign imem_req_o   = req_q;
  assign imem_addr_o  = addr_q;
  assign inst_valid_o = (count != '0);
  assign inst_o       = inst_mem[head];
  assign inst_pc_o    = pc_mem[head];
  assign state_o      = state;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: PC register and memory around the DUT, with a
// reference model and an expected {inst, pc} queue checked every cycle.
module tb_if_fetch_unit;

  localparam int DEPTH = 2;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_DROP = 2'd2;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic [31:0] pc_i;
  logic        pc_en_o;
  logic        flush_i = 1'b0;
  logic        stall_i = 1'b0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i = 1'b0;
  logic [31:0] imem_data_i = '0;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic [1:0]  state_o;

  logic [31:0] flush_target = '0;
  logic [31:0] pc_reg;

  int n_checks = 0;
  int n_errors = 0;

  logic [63:0] exp_q[$];
  logic [1:0]  m_state;
  logic [31:0] m_pc;
  logic [31:0] m_addr;

  if_fetch_unit #(.DEPTH(DEPTH)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .pc_i        (pc_i),
    .pc_en_o     (pc_en_o),
    .flush_i     (flush_i),
    .stall_i     (stall_i),
    .imem_req_o  (imem_req_o),
    .imem_addr_o (imem_addr_o),
    .imem_ack_i  (imem_ack_i),
    .imem_data_i (imem_data_i),
    .inst_valid_o(inst_valid_o),
    .inst_o      (inst_o),
    .inst_pc_o   (inst_pc_o),
    .state_o     (state_o)
  );

  always #5 clk_i = ~clk_i;

  // PC register: redirect target on flush, +4 otherwise, gated by pc_en_o.
  always_ff @(posedge clk_i) begin
    if (rst_i) pc_reg <= '0;
    else if (pc_en_o) pc_reg <= flush_i ? flush_target : pc_reg + 32'd4;
  end
  assign pc_i = pc_reg;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: check registered outputs, drive inputs, check pc_en_o,
  // advance the reference model, then move to just after the next rising edge.
  task automatic step(input logic ack, input logic flush, input logic stall,
                      input logic start, input logic [31:0] target);
    int sz;
    logic [63:0] head;
    check("req", 32'(imem_req_o), 32'(m_state != S_IDLE));
    check("state", 32'(state_o), 32'(m_state));
    if (m_state != S_IDLE) check("addr", imem_addr_o, m_addr);
    check("valid", 32'(inst_valid_o), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      head = exp_q[0];
      check("inst", inst_o, head[63:32]);
      check("inst_pc", inst_pc_o, head[31:0]);
    end
    imem_ack_i   = ack;
    flush_i      = flush;
    stall_i      = stall;
    start_i      = start;
    flush_target = target;
    imem_data_i  = imem_addr_o | 32'hA000_0000;
    #1;
    check("pc_en", 32'(pc_en_o), 32'(flush || (m_state == S_REQ && ack)));
    sz = exp_q.size();
    if (flush) exp_q.delete();
    else if (sz != 0 && !stall) void'(exp_q.pop_front());
    case (m_state)
      S_IDLE: begin
        if (flush) m_pc = target;
        else if (start && sz < DEPTH) begin
          m_state = S_REQ;
          m_addr  = m_pc;
        end
      end
      S_REQ: begin
        if (ack) begin
          m_state = S_IDLE;
          if (flush) m_pc = target;
          else begin
            exp_q.push_back({m_addr | 32'hA000_0000, m_addr});
            m_pc = m_pc + 32'd4;
          end
        end else if (flush) begin
          m_state = S_DROP;
          m_pc    = target;
        end
      end
      default: begin
        if (flush) m_pc = target;
        if (ack) m_state = S_IDLE;
      end
    endcase
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    rst_i   = 1'b1;
    flush_i = 1'b0;
    start_i = 1'b0;
    stall_i = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      imem_ack_i = ~imem_ack_i;
      @(posedge clk_i);
      #1;
    end
    exp_q.delete();
    m_state = S_IDLE;
    m_pc    = '0;
    m_addr  = '0;
    check("rst_req", 32'(imem_req_o), 32'd0);
    check("rst_valid", 32'(inst_valid_o), 32'd0);
    check("rst_inst", inst_o, 32'd0);
    check("rst_inst_pc", inst_pc_o, 32'd0);
    check("rst_addr", imem_addr_o, 32'd0);
    rst_i      = 1'b0;
    imem_ack_i = 1'b0;
    #1;
    check("rst_pc_en", 32'(pc_en_o), 32'd0);
  endtask

  initial begin
    // Reset with ack toggling
    do_reset(2);

    // Streaming with single-cycle ack
    for (int i = 0; i < 8; i++) step(imem_req_o, 1'b0, 1'b0, 1'b1, '0);
    for (int i = 0; i < 4; i++) step(imem_req_o, 1'b0, 1'b0, 1'b0, '0);

    // Back-pressure: fill the queue, then release the stall
    do_reset(1);
    for (int i = 0; i < 8; i++) step(imem_req_o, 1'b0, 1'b1, 1'b1, '0);
    check("pc_hold", pc_reg, 32'h8);
    for (int i = 0; i < 6; i++) step(imem_req_o, 1'b0, 1'b0, 1'b1, '0);
    for (int i = 0; i < 4; i++) step(imem_req_o, 1'b0, 1'b0, 1'b0, '0);

    // Flush while a slow request is in flight
    do_reset(1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h10);
    step(1'b0, 1'b0, 1'b0, 1'b1, '0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 32'h40);
    step(1'b0, 1'b0, 1'b0, 1'b1, '0);
    step(1'b1, 1'b0, 1'b0, 1'b1, '0);
    for (int i = 0; i < 4; i++) step(imem_req_o, 1'b0, 1'b0, 1'b1, '0);
    for (int i = 0; i < 3; i++) step(imem_req_o, 1'b0, 1'b0, 1'b0, '0);

    // Flush coinciding with ack on a non-empty queue, then push+pop at count 1
    do_reset(1);
    for (int i = 0; i < 3; i++) step(imem_req_o, 1'b0, 1'b1, 1'b1, '0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 32'h80);
    check("flush_valid", 32'(inst_valid_o), 32'd0);
    for (int i = 0; i < 3; i++) step(imem_req_o, 1'b0, 1'b1, 1'b1, '0);
    step(imem_req_o, 1'b0, 1'b0, 1'b1, '0);
    check("pushpop_pc", inst_pc_o, 32'h84);
    for (int i = 0; i < 4; i++) step(imem_req_o, 1'b0, 1'b0, 1'b0, '0);

    // Reset in the middle of a request, late ack ignored
    do_reset(1);
    step(imem_req_o, 1'b0, 1'b0, 1'b1, '0);
    do_reset(1);
    step(1'b1, 1'b0, 1'b0, 1'b0, '0);
    step(1'b0, 1'b0, 1'b0, 1'b0, '0);
    check("rst_mid_valid", 32'(inst_valid_o), 32'd0);

    // Random traffic: ack latency, stalls, flushes and start gaps
    do_reset(1);
    for (int i = 0; i < 400; i++) begin
      step(imem_req_o && ($urandom_range(0, 2) != 0),
           $urandom_range(0, 15) == 0,
           $urandom_range(0, 3) == 0,
           $urandom_range(0, 7) != 0,
           32'($urandom_range(0, 1023)) << 2);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
Instruction-fetch stage that sits directly downstream of the PC register. It issues one instruction-memory request per PC value over a req/ack handshake and tells the PC register when it may advance. Fetched instructions go into a small queue that presents {instruction, PC} to the IF/ID pipeline register. Branch flushes discard all queued instructions and any in-flight instruction.

Parameters:
DEPTH, 2, fetch-queue entries (power of two, ≥2)

Ports:
clk_i  input  1  clock; all state updates on rising edge
rst_i  input  1  synchronous reset, active-high
start_i  input  1  CPU run enable; 0 = issue no new requests
pc_i  input  32  current PC from the PC register
pc_en_o  output  1  PC may load its next value (ANDed into the PC's no-hazard enable)
flush_i  input  1  branch taken / redirect; discard queue and in-flight fetch
stall_i  input  1  ID stage stalled; do not pop
imem_req_o  output  1  memory request
imem_addr_o  output  32  request address, stable while imem_req_o=1
imem_ack_i  input  1  response valid; meaningful only while imem_req_o=1
imem_data_i  input  32  instruction data, valid with imem_ack_i
inst_valid_o  output  1  queue head valid
inst_o  output  32  queue head instruction
inst_pc_o  output  32  queue head PC

Behaviour:
- Reset (rst_i=1 at an edge):
  - state=IDLE, queue empty.
  - imem_req_o=0, imem_addr_o=0, inst_valid_o=0, inst_o=0, inst_pc_o=0.
  - Reset overrides everything, including mid-request; a pending ack after reset is ignored.
- State machine: IDLE, REQ, DROP.
  - IDLE → REQ when start_i=1, flush_i=0 and count<DEPTH. On that edge, imem_addr_o<=pc_i.
  - REQ, imem_ack_i=1, flush_i=0: push {imem_data_i, imem_addr_o}, go IDLE.
  - REQ, imem_ack_i=1, flush_i=1: data discarded, go IDLE.
  - REQ, imem_ack_i=0, flush_i=1: go DROP.
  - DROP, imem_ack_i=1: data discarded, go IDLE. flush_i in DROP is absorbed (stay DROP until ack).
- imem_req_o=1 exactly in REQ and DROP (registered, from state).
  - Ack may arrive in the first cycle req is high; latency is unbounded.
- pc_en_o (combinational) = flush_i OR (state==REQ AND imem_ack_i AND NOT flush_i).
  - The PC advances only once per accepted fetch.
  - The PC loads the redirect target in the flush cycle.
- Throughput: with 1-cycle ack, one instruction per 2 cycles.
- Queue:
  - FIFO with count 0..DEPTH.
  - inst_valid_o = count≠0; inst_o/inst_pc_o = head entry (registered storage, no bypass). A pushed instruction is visible the cycle after the ack.
  - Pop when inst_valid_o=1, stall_i=0 and flush_i=0.
  - Push and pop in the same cycle: count unchanged, order preserved.
  - Pointers wrap modulo DEPTH.
- Full rule:
  - No issue when count==DEPTH.
  - In-flight requests are at most 1, and issue only occurs from IDLE, so a push never overflows.
  - A pop in the issue cycle does not enable issue in that cycle.
- Flush: at the edge, count<=0 and head/tail reset. inst_valid_o=0 the next cycle. The next issue uses the redirected pc_i.
- start_i=0: no new issue; an in-flight request completes normally; the queue still drains.
- imem_addr_o holds its last value in IDLE.

Test Plan:
1. Reset:
   - Stimulus: rst_i=1 for 2 cycles with imem_ack_i toggling.
   - Required: imem_req_o=0, inst_valid_o=0, inst_o=0, inst_pc_o=0, pc_en_o=0.
2. Streaming:
   - Stimulus: 1-cycle-ack memory returning data=addr|0xA0000000, PC model starting at 0x0, stall_i=0.
   - Required: imem_addr_o sequence 0x0,0x4,0x8. inst_pc_o 0x0,0x4,0x8 with inst_o 0xA0000000,0xA0000004,0xA0000008. pc_en_o pulses once per ack.
3. Back-pressure:
   - Stimulus: stall_i=1 throughout, DEPTH=2.
   - Required: after 2 pushes imem_req_o stays 0 and the PC holds 0x8. Release stall → pops 0x0 then 0x4 on consecutive cycles, then fetch of 0x8 resumes.
4. Flush in flight:
   - Stimulus: request to 0x10 with ack delayed 3 cycles; flush_i pulsed 1 cycle after req with target 0x40.
   - Required: pc_en_o=1 in the flush cycle, state DROP, the 0x10 data never appears, the next imem_addr_o=0x40.
5. Flush coinciding with ack and non-empty queue:
   - Required: queue emptied, ack data discarded, inst_valid_o=0 next cycle.
   - Separately, simultaneous push/pop at count=1 keeps count=1 with correct order.
6. Reset mid-request:
   - Stimulus: rst_i during REQ, with the ack arriving after reset.
   - Required: no push, IDLE, queue empty.
